// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S slave receiver: synchronizes bck/lrck/sdata to clk and emits one word per channel
module i2s_receiver #(
    parameter int sample_width = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    bck,
    input  logic                    lrck,
    input  logic                    sdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [sample_width-1:0] out_data,
    output logic                    out_chan,
    input  logic                    clear_flags,
    output logic                    overflow,
    output logic                    sync_error
);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, SHIFT, PAD} state_t;

    localparam logic [5:0] last_bit = 6'(sample_width - 1);

    state_t                  state;
    logic                    bck_s1, bck_s2, bck_prev;
    logic                    lrck_s1, lrck_s2, lrck_last;
    logic                    sdata_s1, sdata_s2;
    logic [5:0]              bit_cnt;
    logic [sample_width-2:0] shreg;
    logic                    word_chan;

    logic                    bit_event;
    logic                    boundary;
    logic                    complete;
    logic                    set_ovf;
    logic                    set_sync;
    logic [sample_width-1:0] new_word;

    assign bit_event = bck_s2 & ~bck_prev;
    // lrck changes one bit ahead of the MSB, so the boundary itself carries no word data
    assign boundary  = bit_event & (lrck_s2 != lrck_last);
    assign new_word  = {shreg, sdata_s2};
    assign complete  = enable && (state == SHIFT) && bit_event && !boundary && (bit_cnt == last_bit);
    assign set_ovf   = complete && out_valid && !out_ready;
    assign set_sync  = enable && (state == SHIFT) && boundary;

    always_ff @(posedge clk) begin
        if (reset) begin
            bck_s1     <= 1'b0;
            bck_s2     <= 1'b0;
            bck_prev   <= 1'b0;
            lrck_s1    <= 1'b0;
            lrck_s2    <= 1'b0;
            lrck_last  <= 1'b0;
            sdata_s1   <= 1'b0;
            sdata_s2   <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= 6'd0;
            shreg      <= '0;
            word_chan  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= 1'b0;
            overflow   <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            bck_s1   <= bck;
            bck_s2   <= bck_s1;
            bck_prev <= bck_s2;
            lrck_s1  <= lrck;
            lrck_s2  <= lrck_s1;
            sdata_s1 <= sdata;
            sdata_s2 <= sdata_s1;
            if (bit_event) begin
                lrck_last <= lrck_s2;
            end

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= WAIT_SYNC;
                    WAIT_SYNC: begin
                        if (boundary && !lrck_s2) begin
                            state     <= SHIFT;
                            bit_cnt   <= 6'd0;
                            word_chan <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (boundary) begin
                            state   <= WAIT_SYNC;
                            bit_cnt <= 6'd0;
                        end else if (bit_event) begin
                            shreg   <= new_word[sample_width-2:0];
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == last_bit) begin
                                state <= PAD;
                            end
                        end
                    end
                    PAD: begin
                        if (boundary) begin
                            state     <= SHIFT;
                            bit_cnt   <= 6'd0;
                            word_chan <= lrck_s2;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (complete && (!out_valid || out_ready)) begin
                out_data  <= new_word;
                out_chan  <= word_chan;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            overflow   <= set_ovf  | (overflow   & ~clear_flags);
            sync_error <= set_sync | (sync_error & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - directed bench for i2s_receiver with bck = clk/8 and 32-slot half-frames
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        bck;
    logic        lrck;
    logic        sdata;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_chan;
    logic        clear_flags;
    logic        overflow;
    logic        sync_error;

    int checks = 0;
    int errors = 0;
    logic [24:0] words[$];

    i2s_receiver #(.sample_width(24)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bck(bck),
        .lrck(lrck),
        .sdata(sdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_chan(out_chan),
        .clear_flags(clear_flags),
        .overflow(overflow),
        .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            words.push_back({out_chan, out_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: plain slot; 1: check out_valid latency after this rising bck;
    // 2: pulse clear_flags in the cycle the word completes
    task automatic send_bit(input logic lr, input logic d, input int mode);
        bck = 1'b0;
        lrck = lr;
        sdata = d;
        repeat (4) @(posedge clk);
        #1;
        bck = 1'b1;
        if (mode == 0) begin
            repeat (4) @(posedge clk);
            #1;
        end else begin
            repeat (2) @(posedge clk);
            #1;
            if (mode == 1) check("lat_early", {31'd0, out_valid}, 32'd0);
            if (mode == 2) clear_flags = 1'b1;
            @(posedge clk);
            #1;
            clear_flags = 1'b0;
            if (mode == 1) check("lat_valid", {31'd0, out_valid}, 32'd1);
            if (mode == 2) check("ovf_clr_same_cycle", {31'd0, overflow}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    // slot 0 is the delay bit, slots 1..24 carry the word MSB first
    task automatic send_slots(input logic lr, input logic [23:0] word, input int first, input int last, input int mode);
        for (int i = first; i <= last; i++) begin
            logic d;
            d = (i >= 1 && i <= 24) ? word[24-i] : 1'b0;
            send_bit(lr, d, (i == 24) ? mode : 0);
        end
    endtask

    task automatic send_half(input logic lr, input logic [23:0] word, input int mode);
        send_slots(lr, word, 0, 31, mode);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        bck = 1'b0;
        lrck = 1'b1;
        sdata = 1'b0;
        out_ready = 1'b1;
        clear_flags = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {8'd0, out_data}, 32'd0);
        check("rst_chan", {31'd0, out_chan}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_sync", {31'd0, sync_error}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // enable rises inside a right half-frame; that right data must be ignored
        send_slots(1'b1, 24'hFFFFFF, 0, 4, 0);
        enable = 1'b1;
        send_slots(1'b1, 24'hFFFFFF, 5, 31, 0);
        send_half(1'b0, 24'h123456, 1);
        send_half(1'b1, 24'hABCDEF, 1);
        check("a_count", words.size(), 2);
        check("a_word0", {7'd0, words[0]}, {7'd0, 1'b0, 24'h123456});
        check("a_word1", {7'd0, words[1]}, {7'd0, 1'b1, 24'hABCDEF});
        check("a_ovf", {31'd0, overflow}, 32'd0);
        check("a_sync", {31'd0, sync_error}, 32'd0);

        // consumer stalls for a full frame: left held, right dropped
        out_ready = 1'b0;
        send_half(1'b0, 24'h111111, 0);
        send_half(1'b1, 24'h222222, 0);
        check("b_valid", {31'd0, out_valid}, 32'd1);
        check("b_data", {8'd0, out_data}, {8'd0, 24'h111111});
        check("b_chan", {31'd0, out_chan}, 32'd0);
        check("b_ovf", {31'd0, overflow}, 32'd1);
        check("b_count", words.size(), 2);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b_hold_valid", {31'd0, out_valid}, 32'd1);
        check("b_hold_data", {8'd0, out_data}, {8'd0, 24'h111111});
        enable = 1'b1;
        pulse_clear();
        check("b_ovf_cleared", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("b_drained", {31'd0, out_valid}, 32'd0);
        check("b_count2", words.size(), 3);
        check("b_word", {7'd0, words[2]}, {7'd0, 1'b0, 24'h111111});

        // new overflow and clear_flags in the same cycle: set wins
        out_ready = 1'b0;
        send_half(1'b0, 24'h333333, 0);
        check("c_ovf_before", {31'd0, overflow}, 32'd0);
        send_half(1'b1, 24'h444444, 2);
        check("c_data", {8'd0, out_data}, {8'd0, 24'h333333});
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("c_count", words.size(), 4);
        check("c_word", {7'd0, words[3]}, {7'd0, 1'b0, 24'h333333});
        pulse_clear();
        check("c_ovf_cleared", {31'd0, overflow}, 32'd0);

        // short left half-frame of 10 slots
        send_slots(1'b0, 24'hCCCCCC, 0, 9, 0);
        send_half(1'b1, 24'h555555, 0);
        check("d_sync", {31'd0, sync_error}, 32'd1);
        check("d_count_none", words.size(), 4);
        send_half(1'b0, 24'h666666, 0);
        send_half(1'b1, 24'h777777, 0);
        check("d_count", words.size(), 6);
        check("d_word0", {7'd0, words[4]}, {7'd0, 1'b0, 24'h666666});
        check("d_word1", {7'd0, words[5]}, {7'd0, 1'b1, 24'h777777});
        pulse_clear();
        check("d_sync_cleared", {31'd0, sync_error}, 32'd0);

        // reset after 12 bits of a left word
        send_slots(1'b0, 24'h888888, 0, 12, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("e_rst_valid", {31'd0, out_valid}, 32'd0);
        check("e_rst_data", {8'd0, out_data}, 32'd0);
        check("e_rst_chan", {31'd0, out_chan}, 32'd0);
        check("e_rst_ovf", {31'd0, overflow}, 32'd0);
        check("e_rst_sync", {31'd0, sync_error}, 32'd0);
        reset = 1'b0;
        send_slots(1'b0, 24'h888888, 13, 31, 0);
        send_half(1'b1, 24'h999999, 0);
        check("e_count_none", words.size(), 6);
        send_half(1'b0, 24'hA5A5A5, 0);
        send_half(1'b1, 24'h5A5A5A, 0);
        check("e_count", words.size(), 8);
        check("e_word0", {7'd0, words[6]}, {7'd0, 1'b0, 24'hA5A5A5});
        check("e_word1", {7'd0, words[7]}, {7'd0, 1'b1, 24'h5A5A5A});
        check("e_sync", {31'd0, sync_error}, 32'd0);
        check("e_ovf", {31'd0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter: sample_width, default 24, bits captured per channel word (legal range 8..32).
REQ-002 SHALL have port: clk  input  1  system clock (slot mclk domain); sole clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: enable  input  1  high = capture permitted.
REQ-005 SHALL have port: bck  input  1  I2S bit clock from slot pin, asynchronous to clk.
REQ-006 SHALL have port: lrck  input  1  I2S word clock (0 = left, 1 = right), asynchronous.
REQ-007 SHALL have port: sdata  input  1  I2S serial data, asynchronous.
REQ-008 SHALL have port: out_valid  output  1  a completed word is held on out_data/out_chan.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-010 SHALL have port: out_data  output  sample_width  captured word, MSB first on the wire.
REQ-011 SHALL have port: out_chan  output  1  channel of out_data (0 left, 1 right).
REQ-012 SHALL have port: clear_flags  input  1  single-cycle pulse clearing the sticky flags.
REQ-013 SHALL have port: overflow  output  1  sticky; a word was dropped because the output was occupied.
REQ-014 SHALL have port: sync_error  output  1  sticky; a half-frame ended before sample_width bits were captured.

Function
REQ-015 SHALL pass bck, lrck and sdata each through a 2-flop synchronizer, and SHALL keep one extra bck flop for edge detection.
REQ-016 SHALL define a bit event as the clk cycle in which the synchronized bck is 1 and its previous value is 0; lrck and sdata SHALL be sampled only at bit events.
REQ-017 SHALL detect a half-frame boundary when the lrck sampled at a bit event differs from the lrck sampled at the previous bit event (I2S delay bit); the MSB SHALL be the sdata sampled at the next bit event.
REQ-018 SHALL implement the states IDLE, WAIT_SYNC, SHIFT and PAD.
REQ-019 IDLE: entered on reset or when enable is low (from any state); IDLE -> WAIT_SYNC when enable is high.
REQ-020 WAIT_SYNC: -> SHIFT at a boundary where the new lrck is 0 (left), so the first word output after sync is always left.
REQ-021 SHIFT: at each bit event, shift sdata into the LSB end of the shift register and increment a 6-bit bit counter, which is cleared at the boundary.
REQ-022 SHIFT: when the counter reaches sample_width, the word is complete and the state -> PAD.
REQ-023 PAD: ignore all further bits; at the next boundary -> SHIFT with channel = new lrck.
REQ-024 A boundary in SHIFT with counter < sample_width SHALL discard the partial word, set sync_error and go to WAIT_SYNC; that edge SHALL NOT start a word.
REQ-025 On word completion with out_valid low, SHALL load out_data/out_chan and assert out_valid on the next clk cycle (latency 1 clk after the LSB bit event).
REQ-026 On word completion with out_valid high and out_ready low, SHALL drop the new word, keep the held word unchanged and set overflow.
REQ-027 On word completion in the same cycle that the held word is accepted (out_valid and out_ready high), SHALL load the new word, keep out_valid high and leave overflow unchanged.
REQ-028 A held word SHALL stay valid and stable until accepted, including after enable goes low; out_valid SHALL drop the cycle after acceptance unless REQ-027 applies.
REQ-029 clear_flags SHALL clear overflow and sync_error; a set condition in the same cycle SHALL win.
REQ-030 Counter width SHALL be 6 bits; a half-frame longer than 63 bits SHALL remain in PAD without wrap-around effects.

Reset
REQ-031 Reset SHALL set: state IDLE, out_valid 0, out_data 0, out_chan 0, overflow 0, sync_error 0, counter 0, synchronizer flops 0.
REQ-032 Reset asserted mid-SHIFT SHALL discard the partial word; after release, capture SHALL resume only after the next left boundary.

Verification
REQ-033 SHALL cover: sample_width 24, bck = clk/8, 32 bck per half-frame, left 0x123456, right 0xABCDEF, out_ready high -> words (0, 0x123456) then (1, 0xABCDEF), each with out_valid high 1 clk after its LSB bit event.
REQ-034 SHALL cover: out_ready low for one full frame -> left word held, right word dropped, overflow = 1; clear_flags pulse -> overflow = 0.
REQ-035 SHALL cover: a left half-frame of only 10 bits -> sync_error = 1, no word output, next captured word is the following left channel.
REQ-036 SHALL cover: enable rising while lrck = 1 -> right data ignored; the first output is left with out_chan = 0.
REQ-037 SHALL cover: reset pulse after 12 bits of SHIFT -> all outputs 0; the next complete left word is captured correctly.
REQ-038 SHALL cover: clear_flags in the same cycle as a new overflow -> overflow remains 1.
